sseg_scan_decoder: RTL
======================

// Module: sseg_scan_decoder
// PURPOSE
// Receive side of the multiplexed 7-segment display bus (an/sseg). Samples the
// scanned, active-low anode/segment lines and rebuilds the four shown digits
// plus the binary value. Used as the display-bus monitor in the meter bench and
// as a loop-back checker on board. Also reports flash blanking and bus faults.
// PARAMETERS
// SETTLE_CYCLES  16    clk cycles an must hold one-hot-low before sseg is sampled (>=2)
// BLANK_CYCLES   8192  clk cycles of an==4'b1111 before blank is asserted
// PORTS
// clk          in   1   system clock
// rst_n        in   1   asynchronous active-low reset
// an           in   4   anodes, active-low, an[0] = rightmost digit
// sseg         in   7   segments, active-low, bit0=a .. bit6=g
// digit0..3    out  4   each: last committed hex digit, digit0 = rightmost
// value        out  14  d3*1000+d2*100+d1*10+d0 of the last all-BCD frame
// frame_valid  out  1   one-cycle pulse: a new frame was committed
// blank        out  1   display dark for >= BLANK_CYCLES
// seg_err      out  1   one-cycle pulse: sampled pattern is not a hex glyph
// an_err       out  1   one-cycle pulse: more than one anode low
// BEHAVIOUR
// Reset: all outputs 0; state WAIT; seen[3:0]=0; counters 0.
// FSM (registered, in the shared package enum):
//  WAIT   : an one-hot-low -> SETTLE, cnt=1. Otherwise stay.
//  SETTLE : an unchanged -> cnt++. When cnt==SETTLE_CYCLES-1, sample sseg -> HELD.
//           an changes -> WAIT.
//  HELD   : an unchanged -> stay. No resample. an changes -> WAIT, same cycle
//           re-evaluated as WAIT input.
// Sample:
//  - Glyph valid: write slot[k], where k is the low anode index; set seen[k].
//  - Glyph invalid: seg_err pulse; slot and seen are unchanged.
// Commit: the cycle after seen==4'b1111:
//  - digit0..3 <= slots; frame_valid pulse; seen <= 0.
//  - All slots <=9: value updates. Otherwise value holds.
// Digit order within a frame is free. A repeated digit overwrites its slot.
// an with >=2 bits low: an_err pulse on every such cycle; FSM -> WAIT.
// Blank counter:
//  - Counts cycles with an==4'b1111 and saturates at BLANK_CYCLES.
//  - blank=1 at saturation.
//  - Any non-1111 an clears the counter, and clears blank on the next valid sample.
//  - seen is not cleared by blanking (a frame may span a flash gap).
// Latency: sseg sampled SETTLE_CYCLES-1 clks after an becomes stable. frame_valid
// fires 1 clk after the fourth distinct digit is sampled. value is valid in the same
// cycle as frame_valid.
// Arithmetic: value computed in 14 bits, max 9999, no overflow.
// rst_n asserted mid-frame clears everything asynchronously; no partial commit.
// CONFIGURATION
// SSEG_DP_EN:
//  - Defined: adds input dp (1b, active-low) and output dp_pos[3:0].
//  - dp is sampled with sseg. dp_pos[k] = dp low on digit k, committed with the frame.
//  - Undefined: no dp port; dp_pos is tied 4'b0000.
// STRUCTURE
// Package sseg_pkg:
//  - state enum {WAIT,SETTLE,HELD}
//  - SEG_GLYPH[16] constant table (0->7'b1000000 .. F->7'b0001110)
//  - NUM_DIGITS=4
// Sub-module sseg_glyph_decode (combinational):
//  - sseg[6:0] -> {hit, hex[3:0]}
//  - Reverse lookup on SEG_GLYPH.
// TESTING
// 1. Scan 1,2,3,4 (digit3..0), 1000 clk per digit, one pass -> frame_valid once;
//    digit3..0=1,2,3,4; value=1234.
// 2. an held 1 clk shorter than SETTLE_CYCLES before changing -> no sample;
//    seen unchanged; no frame_valid.
// 3. an=4'b1100 for 3 clks -> an_err high 3 clks; FSM WAIT; slots unchanged.
// 4. Frame showing 0,0,A,5 -> frame_valid; digit1=A; value keeps previous 1234.
//    Then sseg=7'b1111111 on digit0 -> seg_err pulse.
// 5. Frame 0200, then an=1111 for BLANK_CYCLES -> blank=1. Resume scan -> blank=0
//    after first sample; next frame_valid; value=200.
// 6. rst_n low mid-scan, after 2 digits -> outputs 0 immediately. After release, a
//    full 4-digit scan is needed before frame_valid.

Source files
------------

// File: rtl/sseg_pkg.sv
// Shared types and glyph table for the 7-segment scan-bus decoder.
// Optional decimal-point capture is enabled by the SSEG_DP_EN macro.
package sseg_pkg;

    localparam int NUM_DIGITS = 4;

    typedef enum logic [1:0] {
        WAIT,
        SETTLE,
        HELD
    } state_t;

    localparam logic [6:0] SEG_GLYPH [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    function automatic logic [13:0] bcd_value(
        input logic [3:0] d3,
        input logic [3:0] d2,
        input logic [3:0] d1,
        input logic [3:0] d0
    );
        return 14'(d3) * 14'd1000
             + 14'(d2) * 14'd100
             + 14'(d1) * 14'd10
             + 14'(d0);
    endfunction

endpackage

// File: rtl/sseg_glyph_decode.sv
// Reverse lookup of an active-low segment pattern onto its hex digit.
// Uses the shared glyph table; unmatched patterns report hit=0.
module sseg_glyph_decode
    import sseg_pkg::*;
(
    input  logic [6:0] sseg,
    output logic       hit,
    output logic [3:0] hex
);

    always_comb begin
        hit = 1'b0;
        hex = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (sseg == SEG_GLYPH[i]) begin
                hit = 1'b1;
                hex = 4'(i);
            end
        end
    end

endmodule

// File: rtl/sseg_scan_decoder.sv
// Rebuilds four digits and a BCD value from a scanned an/sseg display bus.
// Define SSEG_DP_EN to add the dp input and capture of decimal-point position.
module sseg_scan_decoder
    import sseg_pkg::*;
#(
    parameter int SETTLE_CYCLES = 16,
    parameter int BLANK_CYCLES  = 8192
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  an,
    input  logic [6:0]  sseg,
`ifdef SSEG_DP_EN
    input  logic        dp,
`endif
    output logic [3:0]  digit0,
    output logic [3:0]  digit1,
    output logic [3:0]  digit2,
    output logic [3:0]  digit3,
    output logic [13:0] value,
    output logic        frame_valid,
    output logic        blank,
    output logic        seg_err,
    output logic        an_err,
    output logic [3:0]  dp_pos
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam int BW = $clog2(BLANK_CYCLES + 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    an_lat_q, an_lat_d;
    logic [3:0]    slot_q [NUM_DIGITS];
    logic [3:0]    slot_d [NUM_DIGITS];
    logic [3:0]    digit_q [NUM_DIGITS];
    logic [3:0]    digit_d [NUM_DIGITS];
    logic [3:0]    seen_q, seen_d;
    logic [13:0]   value_q, value_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          fv_q, fv_d;
    logic          blank_q, blank_d;
    logic          seg_err_q, seg_err_d;
    logic          an_err_q, an_err_d;

    logic [3:0] lows;
    logic       one_hot;
    logic       multi;
    logic [1:0] idx;
    logic       sample;
    logic       take;
    logic       commit;
    logic       hit;
    logic [3:0] hex;

    sseg_glyph_decode u_dec (
        .sseg (sseg),
        .hit  (hit),
        .hex  (hex)
    );

    assign lows    = ~an;
    assign one_hot = (lows != 4'b0) && ((lows & (lows - 4'd1)) == 4'b0);
    assign multi   = (lows != 4'b0) && !one_hot;
    assign commit  = (seen_q == 4'b1111);
    assign take    = sample && hit;

    always_comb begin
        idx = 2'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an[i]) idx = 2'(i);
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        an_lat_d = an_lat_q;
        sample   = 1'b0;
        an_err_d = 1'b0;
        if (multi) begin
            state_d  = WAIT;
            an_err_d = 1'b1;
        end else begin
            unique case (state_q)
                WAIT: begin
                    if (one_hot) begin
                        state_d  = SETTLE;
                        cnt_d    = CW'(1);
                        an_lat_d = an;
                    end
                end
                SETTLE: begin
                    if (an != an_lat_q) begin
                        state_d = WAIT;
                    end else if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
                        sample  = 1'b1;
                        state_d = HELD;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                HELD: begin
                    // A new digit is picked up in the same cycle it appears.
                    if (an != an_lat_q) begin
                        if (one_hot) begin
                            state_d  = SETTLE;
                            cnt_d    = CW'(1);
                            an_lat_d = an;
                        end else begin
                            state_d = WAIT;
                        end
                    end
                end
                default: state_d = WAIT;
            endcase
        end
    end

    always_comb begin
        slot_d    = slot_q;
        digit_d   = digit_q;
        seen_d    = seen_q;
        value_d   = value_q;
        fv_d      = 1'b0;
        seg_err_d = 1'b0;
        if (commit) begin
            digit_d = slot_q;
            fv_d    = 1'b1;
            seen_d  = 4'b0;
            if (slot_q[0] <= 4'd9 && slot_q[1] <= 4'd9 &&
                slot_q[2] <= 4'd9 && slot_q[3] <= 4'd9) begin
                value_d = bcd_value(slot_q[3], slot_q[2],
                                    slot_q[1], slot_q[0]);
            end
        end
        if (take) begin
            slot_d[idx] = hex;
            seen_d[idx] = 1'b1;
        end else if (sample) begin
            seg_err_d = 1'b1;
        end
    end

    always_comb begin
        bcnt_d  = bcnt_q;
        blank_d = blank_q;
        if (an == 4'b1111) begin
            if (bcnt_q != BW'(BLANK_CYCLES)) bcnt_d = bcnt_q + BW'(1);
        end else begin
            bcnt_d = '0;
        end
        if (bcnt_d == BW'(BLANK_CYCLES)) blank_d = 1'b1;
        if (take) blank_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= WAIT;
            cnt_q     <= '0;
            an_lat_q  <= 4'b0;
            slot_q    <= '{default: '0};
            digit_q   <= '{default: '0};
            seen_q    <= 4'b0;
            value_q   <= 14'd0;
            bcnt_q    <= '0;
            fv_q      <= 1'b0;
            blank_q   <= 1'b0;
            seg_err_q <= 1'b0;
            an_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            an_lat_q  <= an_lat_d;
            slot_q    <= slot_d;
            digit_q   <= digit_d;
            seen_q    <= seen_d;
            value_q   <= value_d;
            bcnt_q    <= bcnt_d;
            fv_q      <= fv_d;
            blank_q   <= blank_d;
            seg_err_q <= seg_err_d;
            an_err_q  <= an_err_d;
        end
    end

`ifdef SSEG_DP_EN
    logic [3:0] dps_q, dps_d;
    logic [3:0] dp_pos_q, dp_pos_d;

    always_comb begin
        dps_d    = dps_q;
        dp_pos_d = dp_pos_q;
        if (commit) dp_pos_d = dps_q;
        if (take) dps_d[idx] = ~dp;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dps_q    <= 4'b0;
            dp_pos_q <= 4'b0;
        end else begin
            dps_q    <= dps_d;
            dp_pos_q <= dp_pos_d;
        end
    end

    assign dp_pos = dp_pos_q;
`else
    assign dp_pos = 4'b0000;
`endif

    assign digit0      = digit_q[0];
    assign digit1      = digit_q[1];
    assign digit2      = digit_q[2];
    assign digit3      = digit_q[3];
    assign value       = value_q;
    assign frame_valid = fv_q;
    assign blank       = blank_q;
    assign seg_err     = seg_err_q;
    assign an_err      = an_err_q;

endmodule
